icache_loader: RTL
==================

# icache_loader

Write-side companion to the instruction-cache read path. Accepts a byte stream from the program/boot source over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes each word into the 4096-entry icache array at consecutive word addresses; the word index matches fetch's `pc[13:2]`. Holds `busy` so fetch can be stalled until the image is resident.

## Interface
- `DEPTH`, 4096, icache entries (words)
- `ADDR_W`, 12, word-address width, log2(DEPTH)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a load; sampled only in IDLE
- `base_addr`  in  ADDR_W  first word index, latched on accepted `start`
- `word_count`  in  ADDR_W+1  words to load, 0..DEPTH, latched on accepted `start`
- `byte_valid`  in  1  source has a byte
- `byte_data`  in  8  stream byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `wr_en`  out  1  icache write strobe, one cycle per word
- `wr_addr`  out  ADDR_W  icache word index
- `wr_data`  out  32  assembled instruction
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when the load completes
- `checksum`  out  32  only with `ICACHE_LOADER_CHECKSUM_EN`

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: `byte_ready`=0. On `start`=1, latch `base_addr`/`word_count`, clear the byte lane and checksum.
  - `word_count`!=0: go to LOAD.
  - `word_count`=0: go to DONE; no write.
- LOAD: `byte_ready`=1. A handshake (`byte_valid & byte_ready`) stores `byte_data` in lane `byte_idx`; the first byte goes to bits 7:0. `byte_idx` is a 2-bit counter.
- 4th byte accepted: register `wr_en`=1, `wr_addr`=current address, `wr_data`=assembled word for the next cycle. Then increment the address modulo DEPTH (0xFFF wraps to 0x000) and decrement the remaining count.
- 4th byte of the final word accepted: go to DONE.
- DONE: one cycle, `done`=1, `byte_ready`=0; then IDLE.
- `start` is ignored in LOAD and DONE.
- `byte_valid` gaps stall assembly with no side effects. Bytes offered outside LOAD are not consumed.
- Reset while loading: back to IDLE. The partial word is discarded and no write is issued.

## Timing
- Reset values: `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `checksum`=0.
- `byte_ready` is decoded from state only; it never depends on `byte_valid`.
- Throughput: at most one byte per cycle, so at least 4 cycles per word.
- `wr_en` is high exactly one cycle, the cycle after the 4th handshake. It may coincide with acceptance of the next word's first byte.
- Accepted `start` at edge T: `busy`=1 from T+1.
- Final byte accepted at edge N: cycle N+1 has `wr_en`=1 (last word), `done`=1, state DONE. Cycle N+2 is IDLE with `busy`=0.
- `word_count`=0: `done`=1 in cycle T+1; IDLE at T+2.
- `wr_addr`/`wr_data` hold their last values while `wr_en`=0.

## Configuration
- `ICACHE_LOADER_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - Holds the 32-bit sum, modulo 2^32, of all words written in the current load.
  - Cleared on accepted `start`; updated on the edge that raises `wr_en`.
  - Final value is valid when `done`=1 and held until the next `start`.
- Not defined: port and adder absent; all other behaviour identical.

## Structure
- Shared `icache_pkg`: `ICACHE_DEPTH`=4096, `ICACHE_ADDR_W`=12, enum `loader_state_t` {IDLE, LOAD, DONE}. The read path uses the same constants.
- One sub-module, `icache_word_packer`: byte lane counter plus 32-bit shift/assemble register. Outputs a `word_valid` pulse and the word. The FSM, address/count counters and checksum stay in the top.

## Test plan
- Reset: hold `rst_n`=0 while driving `start`/`byte_valid` → all outputs 0, no `wr_en`.
- Two-word load, `base_addr`=0x010, `word_count`=2, bytes 13 00 00 00 93 00 10 00 back-to-back:
  - `wr_en` at 0x010 data 0x00000013, then at 0x011 data 0x00100093.
  - `done` pulses with the second write; `checksum`=0x001000A6.
- Same load with 1–3 idle cycles of `byte_valid`=0 between bytes → identical writes and checksum; `wr_en` only after each 4th byte.
- Wrap: `base_addr`=0xFFF, `word_count`=2 → writes to 0xFFF, then 0x000.
- `word_count`=0 → `done` one cycle after `start`, no `wr_en`, `busy` high exactly 1 cycle. A `start` pulsed while `busy` is ignored.
- Reset mid-load after 2 bytes → no write, IDLE. A fresh load of 4 bytes AA BB CC DD at 0x020 → writes 0xDDCCBBAA.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared icache constants and loader state encoding.
// Used by both the icache read path and icache_loader.
package icache_pkg;
  localparam int ICACHE_DEPTH  = 4096;
  localparam int ICACHE_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;
endpackage

// File: rtl/icache_word_packer.sv
// Assembles four stream bytes into a little-endian 32-bit word.
// o_word_valid pulses combinationally with the 4th accepted byte.
module icache_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  logic [1:0]  r_idx;
  logic [23:0] r_lanes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 2'd0;
      r_lanes <= 24'd0;
    end else if (i_clear) begin
      r_idx   <= 2'd0;
      r_lanes <= 24'd0;
    end else if (i_byte_en) begin
      r_idx <= r_idx + 2'd1;
      unique case (r_idx)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: r_lanes        <= 24'd0;
      endcase
    end
  end

  // Top lane comes straight from the input so the word is ready on the 4th byte
  assign o_word_valid = i_byte_en & (r_idx == 2'd3);
  assign o_word       = {i_byte, r_lanes};
endmodule

// File: rtl/icache_loader.sv
// Byte-stream loader that writes 32-bit words into the icache array.
// Define ICACHE_LOADER_CHECKSUM_EN to add the o_checksum word sum.
module icache_loader
  import icache_pkg::*;
#(
  parameter int DEPTH  = ICACHE_DEPTH,
  parameter int ADDR_W = ICACHE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_word_count,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done
`ifdef ICACHE_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       o_checksum
`endif
);
  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_busy;
  logic              r_done;

  logic              w_hs;
  logic              w_accept;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign o_byte_ready = (r_state == LOAD);
  assign w_hs         = i_byte_valid & o_byte_ready;
  assign w_accept     = (r_state == IDLE) & i_start;
  assign w_addr_nxt   = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;

  icache_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_accept),
    .i_byte_en    (w_hs),
    .i_byte       (i_byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr <= i_base_addr;
            r_cnt  <= i_word_count;
            r_busy <= 1'b1;
            if (i_word_count == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_word_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_word;
            r_addr    <= w_addr_nxt;
            r_cnt     <= r_cnt - 1'b1;
            if (r_cnt == (ADDR_W+1)'(1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= 32'd0;
    end else if (w_accept) begin
      r_sum <= 32'd0;
    end else if (w_word_valid) begin
      r_sum <= r_sum + w_word;
    end
  end

  assign o_checksum = r_sum;
`endif

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
endmodule
